piezo_request_arbiter: RTL and testbench

- Shares the single piezo tone generator among three requesters inside the vending machine: keypad click, vend-success melody and error alarm.
- Latches one-shot request pulses and grants them by fixed priority.
- Steps the granted requester's note sequence with programmable note and gap timing.
- Drives the 3-bit note code consumed by the piezo tone generator.

---
 rtl/piezo_request_arbiter.sv | 95 +++++++++
 tb/tb_piezo_request_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/piezo_request_arbiter.sv
// piezo_request_arbiter: latches one-shot tone requests, grants by fixed priority (err > vend > key)
// and steps the granted note sequence with programmable note and gap timing.
module piezo_request_arbiter #(
    parameter int NOTE_TICKS = 250000,
    parameter int GAP_TICKS  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_key,
    input  logic       req_vend,
    input  logic       req_err,
    input  logic       mute,
    output logic [2:0] note_code,
    output logic [1:0] active_src,
    output logic       busy,
    output logic       done
);
    localparam int MAXT = NOTE_TICKS > GAP_TICKS ? NOTE_TICKS : GAP_TICKS;
    localparam int CW   = $clog2(MAXT);
    localparam logic [1:0] SRC_KEY = 2'd1, SRC_VEND = 2'd2, SRC_ERR = 2'd3;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    idx, idx_nx, src, src_nx;
    logic [2:0]    pend, pend_nx, grant, note;
    logic          done_nx, last;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            src   <= '0;
            pend  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            src   <= src_nx;
            pend  <= pend_nx;
            done  <= done_nx;
        end

    // pend bits: [2]=err, [1]=vend, [0]=key
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        src_nx   = src;
        grant    = '0;
        done_nx  = 1'b0;
        last     = (src == SRC_KEY) ? (idx == 2'd0) : (idx == 2'd3);
        if (state == IDLE) begin
            cnt_nx = '0;
            if (|pend) begin
                state_nx = PLAY;
                idx_nx   = '0;
                src_nx   = pend[2] ? SRC_ERR : pend[1] ? SRC_VEND : SRC_KEY;
                grant    = pend[2] ? 3'b100 : pend[1] ? 3'b010 : 3'b001;
            end
        end else if (pend[2] && src != SRC_ERR) begin
            state_nx = PLAY;
            cnt_nx   = '0;
            idx_nx   = '0;
            src_nx   = SRC_ERR;
            grant    = 3'b100;
        end else if (state == PLAY && cnt == CW'(NOTE_TICKS - 1)) begin
            state_nx = GAP;
            cnt_nx   = '0;
        end else if (state == GAP && cnt == CW'(GAP_TICKS - 1)) begin
            state_nx = last ? IDLE : PLAY;
            cnt_nx   = '0;
            idx_nx   = last ? idx : idx + 2'd1;
            done_nx  = last;
        end
        pend_nx = (pend & ~grant) | {req_err, req_vend, req_key};
    end

    always_comb begin
        note = 3'd0;
        if (src == SRC_KEY)
            note = 3'd5;
        else if (src == SRC_VEND)
            note = {idx, 1'b1};
        else if (src == SRC_ERR)
            note = idx[0] ? 3'd1 : 3'd7;
    end

    assign note_code  = (state == PLAY && !mute) ? note : 3'd0;
    assign active_src = (state == IDLE) ? 2'd0 : src;
    assign busy       = (state != IDLE) | (|pend);
endmodule

// File: tb/tb_piezo_request_arbiter.sv
// tb_piezo_request_arbiter: per-cycle scoreboard of expected note/src/busy/done traces
// built from the sequence timing, compared against the arbiter with NOTE_TICKS=4, GAP_TICKS=2.
module tb_piezo_request_arbiter;
    localparam int NT = 4, GT = 2, P = NT + GT, L = 64;

    logic       clk = 1'b0, rst = 1'b0;
    logic       req_key = 1'b0, req_vend = 1'b0, req_err = 1'b0, mute = 1'b0;
    logic [2:0] note_code;
    logic [1:0] active_src;
    logic       busy, done;
    int         errors = 0, checks = 0;

    typedef struct packed {
        logic [2:0] n;
        logic [1:0] s;
        logic       b;
        logic       d;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] en[L];
    logic [1:0] es[L];
    logic       eb[L], ed[L], rk[L], rv[L], re[L], mu[L];

    always #5 clk = ~clk;

    piezo_request_arbiter #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .req_key(req_key), .req_vend(req_vend), .req_err(req_err),
        .mute(mute), .note_code(note_code), .active_src(active_src), .busy(busy), .done(done)
    );

    task check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task clear();
        for (int i = 0; i < L; i++) begin
            en[i] = 0; es[i] = 0; eb[i] = 0; ed[i] = 0;
            rk[i] = 0; rv[i] = 0; re[i] = 0; mu[i] = 0;
        end
    endtask

    task play(input int start, input logic [1:0] s, input logic [2:0] c0, c1, c2, c3, input int n);
        logic [2:0] codes[4];
        codes = '{c0, c1, c2, c3};
        for (int i = 0; i < n; i++)
            for (int t = 0; t < P; t++) begin
                en[start + i*P + t] = (t < NT) ? codes[i] : 3'd0;
                es[start + i*P + t] = s;
                eb[start + i*P + t] = 1'b1;
            end
        ed[start + n*P] = 1'b1;
    endtask

    task do_reset();
        rst = 1'b0; req_key = 0; req_vend = 0; req_err = 0; mute = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task run(input string name, input int len);
        exp_t e;
        for (int c = 0; c < len; c++) begin
            e.n = mu[c] ? 3'd0 : en[c];
            e.s = es[c];
            e.b = eb[c];
            e.d = ed[c];
            sb.push_back(e);
        end
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            req_key = rk[c]; req_vend = rv[c]; req_err = re[c]; mute = mu[c];
            @(negedge clk);
            if (sb.size() == 0) begin
                check($sformatf("%s c%0d sb_empty", name, c), 8'd1, 8'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s c%0d note", name, c), {5'd0, note_code}, {5'd0, e.n});
                check($sformatf("%s c%0d src", name, c), {6'd0, active_src}, {6'd0, e.s});
                check($sformatf("%s c%0d busy", name, c), {7'd0, busy}, {7'd0, e.b});
                check($sformatf("%s c%0d done", name, c), {7'd0, done}, {7'd0, e.d});
            end
        end
        req_key = 0; req_vend = 0; req_err = 0; mute = 0;
    endtask

    initial begin
        #2;
        check("reset note", {5'd0, note_code}, 8'd0);
        check("reset src", {6'd0, active_src}, 8'd0);
        check("reset busy", {7'd0, busy}, 8'd0);
        check("reset done", {7'd0, done}, 8'd0);

        do_reset(); clear();
        rk[0] = 1; eb[1] = 1;
        play(2, 2'd1, 3'd5, 3'd0, 3'd0, 3'd0, 1);
        run("key", 10);

        do_reset(); clear();
        rv[0] = 1; eb[1] = 1;
        play(2, 2'd2, 3'd1, 3'd3, 3'd5, 3'd7, 4);
        run("vend", 28);

        do_reset(); clear();
        rk[0] = 1; rv[0] = 1; eb[1] = 1;
        play(2, 2'd2, 3'd1, 3'd3, 3'd5, 3'd7, 4);
        eb[26] = 1;
        play(27, 2'd1, 3'd5, 3'd0, 3'd0, 3'd0, 1);
        run("both", 35);

        do_reset(); clear();
        rv[0] = 1; re[9] = 1; eb[1] = 1;
        play(2, 2'd2, 3'd1, 3'd3, 3'd5, 3'd7, 4);
        for (int c = 11; c < L; c++) begin
            en[c] = 0; es[c] = 0; eb[c] = 0; ed[c] = 0;
        end
        play(11, 2'd3, 3'd7, 3'd1, 3'd7, 3'd1, 4);
        run("preempt", 37);

        do_reset(); clear();
        rk[0] = 1; rk[1] = 1; eb[1] = 1;
        for (int c = 0; c <= 8; c++) mu[c] = 1;
        play(2, 2'd1, 3'd5, 3'd0, 3'd0, 3'd0, 1);
        eb[8] = 1;
        play(9, 2'd1, 3'd5, 3'd0, 3'd0, 3'd0, 1);
        run("mute", 17);

        do_reset(); clear();
        rv[0] = 1; eb[1] = 1;
        play(2, 2'd2, 3'd1, 3'd3, 3'd5, 3'd7, 4);
        run("prerst", 4);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst note", {5'd0, note_code}, 8'd0);
        check("midrst src", {6'd0, active_src}, 8'd0);
        check("midrst busy", {7'd0, busy}, 8'd0);
        check("midrst done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        clear();
        run("postrst", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
